poly_osc: RTL and testbench
===========================

# poly_osc

Parametrised multi-voice oscillator for the synth datapath. Each of `NUM_VOICES` voices converts a clamped MIDI note into a square or pulse wave, with per-voice gate, phase sync and duty mode. Period changes are glitch-free. A registered voice-count mix is provided for the output DAC/PWM stage. Voice periods are derived from an elaboration-time top-octave table plus an octave shift.

## Interface
- `F_CLK_HZ`, 10_000_000: system clock frequency in Hz.
- `NUM_VOICES`, 4: number of independent voices (≥1).
- `CNT_BW`, 19: width of each voice's full-period counter.
- `MIX_BW`, $clog2(NUM_VOICES+1): mix output width (derived localparam).
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `note_i`  in  8*NUM_VOICES  MIDI note per voice; voice v uses bits [8v+7:8v].
- `gate_i`  in  NUM_VOICES  voice enable (level).
- `sync_i`  in  NUM_VOICES  phase restart (level, sampled each cycle).
- `mode_i`  in  2*NUM_VOICES  duty mode per voice: 0 = 50 %, 1 = 25 %, 2 = 12.5 %, 3 = 50 % inverted (low first).
- `wave_o`  out  NUM_VOICES  per-voice waveform.
- `wrap_o`  out  NUM_VOICES  one-cycle strobe on the last cycle of each period.
- `mix_o`  out  MIX_BW  registered count of voices whose `wave_o` is high.

## Operation
- Note clamp: n < 21 → 21; n > 127 → 127.
- Period table: `TOP[s]` for s = 0..11 is floor(F_CLK_HZ·1000 / (2·FmHz[s])), computed in 64-bit elaboration-time arithmetic. FmHz = {8372018, 8869844, 9397273, 9956063, 10548082, 11175303, 11839822, 12543854, 13289750, 14080000, 14917240, 15804266}, i.e. notes 120..131.
- Half period: `half = TOP[n%12] << (10 − n/12)`. If 2·half > 2^CNT_BW − 1, half saturates to 2^(CNT_BW−1) − 1.
- Per-voice state: `active`, `cnt` [CNT_BW], latched `half_q`, latched `mode_q`.
- Threshold `thr` from `mode_q`: modes 0/3 → half_q; mode 1 → half_q>>1; mode 2 → half_q>>2.
- `wave_o[v] = active & ((cnt < thr) XOR (mode_q==3))`. Driven from flops only, no combinational path from inputs.
- Voice states:
  - IDLE (active = 0): `cnt` held at 0 and `wave_o` = 0. `gate_i` = 1 → RUN with cnt ← 0, half_q ← half(note_i), mode_q ← mode_i.
  - RUN (active = 1): `gate_i` = 0 → IDLE with cnt ← 0. Otherwise, `sync_i` = 1 → cnt ← 0 and relatch half/mode. Otherwise, cnt == 2·half_q − 1 → cnt ← 0, relatch half/mode, `wrap_o` = 1 this cycle. Otherwise cnt ← cnt + 1.
- Note and mode changes during RUN take effect only at wrap or sync. This is the glitch-free rule.
- Priority per edge: gate low > sync > wrap > count.
- `sync_i` in IDLE is ignored.
- `mix_o` ← popcount(`wave_o`), registered.
- Voices are fully independent. There is no shared arithmetic that stalls a voice.

## Timing
- Reset: every `active`, `cnt`, `half_q`, `mode_q`, `wave_o`, `wrap_o` and `mix_o` = 0. Reset asserted mid-operation clears all of these immediately, regardless of clock.
- Gate rise seen at edge k: `wave_o` high from cycle k+1 (modes 0–2). Mode 3 is low first.
- In RUN, `wave_o` is high for exactly `thr` cycles and the period is exactly 2·half_q cycles.
- `wrap_o` is high in the final cycle of each period. The next cycle has cnt = 0.
- Sync seen at edge k: cycle k+1 has cnt = 0. No `wrap_o` is issued for the truncated period.
- Gate fall seen at edge k: `wave_o` = 0 from cycle k+1.
- `mix_o` lags `wave_o` by 1 cycle.

## Test plan
- Note 69, mode 0, gate 1 (defaults) → half = 355<<5 = 11360. `wave_o` high 11360 / low 11360 cycles. `wrap_o` every 22720 cycles.
- Note 69, mode 1 → high 5680 / low 17040. Mode 3 → low 11360 first, then high 11360.
- Clamp: note 0 → half 181760 (A0 period 363520). Note 200 → half 398 (G9 period 796).
- Change note 69 → 81 mid-period → current period completes at 22720, then period 11360 (half 5680). `sync_i` pulse at cycle 5000 of a period → cnt 0 next cycle, no `wrap_o`.
- Four voices on notes 60/64/67/72 with staggered gates → `mix_o` equals the popcount of the previous-cycle `wave_o`, every cycle, over 200k cycles.
- `rst_i` asserted mid-high and between edges → all outputs 0 immediately. After release with gate held, the voice restarts at cnt 0 with `wave_o` high on the next cycle.

Source files
------------

// File: rtl/poly_osc.sv
// rtl/poly_osc.sv - multi-voice square/pulse oscillator with glitch-free period updates and registered voice mix
module poly_osc #(
    parameter int F_CLK_HZ   = 10_000_000,
    parameter int NUM_VOICES = 4,
    parameter int CNT_BW     = 19,
    localparam int MIX_BW    = $clog2(NUM_VOICES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [8*NUM_VOICES-1:0] note_i,
    input  logic [NUM_VOICES-1:0]   gate_i,
    input  logic [NUM_VOICES-1:0]   sync_i,
    input  logic [2*NUM_VOICES-1:0] mode_i,
    output logic [NUM_VOICES-1:0]   wave_o,
    output logic [NUM_VOICES-1:0]   wrap_o,
    output logic [MIX_BW-1:0]       mix_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [63:0] top_calc(input int s);
        logic [63:0] fm;
        case (s)
            0:       fm = 64'd8372018;
            1:       fm = 64'd8869844;
            2:       fm = 64'd9397273;
            3:       fm = 64'd9956063;
            4:       fm = 64'd10548082;
            5:       fm = 64'd11175303;
            6:       fm = 64'd11839822;
            7:       fm = 64'd12543854;
            8:       fm = 64'd13289750;
            9:       fm = 64'd14080000;
            10:      fm = 64'd14917240;
            default: fm = 64'd15804266;
        endcase
        return (64'(F_CLK_HZ) * 64'd1000) / (64'd2 * fm);
    endfunction

    // Half periods of the top octave (notes 120..131); lower octaves shift left.
    localparam logic [63:0] TOP [12] = '{
        top_calc(0), top_calc(1), top_calc(2),  top_calc(3),
        top_calc(4), top_calc(5), top_calc(6),  top_calc(7),
        top_calc(8), top_calc(9), top_calc(10), top_calc(11)
    };

    localparam logic [63:0] CNT_MAX  = (64'd1 << CNT_BW) - 64'd1;
    localparam logic [63:0] HALF_SAT = (64'd1 << (CNT_BW - 1)) - 64'd1;

    function automatic logic [CNT_BW-1:0] calc_half(input logic [7:0] note);
        logic [7:0]  n;
        logic [3:0]  semi;
        logic [3:0]  oct;
        logic [63:0] h;
        if (note < 8'd21)       n = 8'd21;
        else if (note > 8'd127) n = 8'd127;
        else                    n = note;
        semi = 4'(n % 8'd12);
        oct  = 4'(n / 8'd12);
        h    = TOP[semi] << (4'd10 - oct);
        if ((h << 1) > CNT_MAX) return HALF_SAT[CNT_BW-1:0];
        return h[CNT_BW-1:0];
    endfunction

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        state_t            state_q, state_d;
        logic [CNT_BW-1:0] cnt_q, cnt_d;
        logic [CNT_BW-1:0] half_q, half_d;
        logic [1:0]        mode_q, mode_d;
        logic [CNT_BW-1:0] half_new;
        logic [CNT_BW-1:0] thr;
        logic              term;

        assign half_new = calc_half(note_i[8*v +: 8]);
        assign term     = (cnt_q == ({half_q[CNT_BW-2:0], 1'b0} - CNT_BW'(1)));

        always_comb begin
            thr = half_q;
            case (mode_q)
                2'd1:    thr = half_q >> 1;
                2'd2:    thr = half_q >> 2;
                default: thr = half_q;
            endcase
        end

        // Note/mode are only sampled on start, wrap or sync so a period is never cut short.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            half_d  = half_q;
            mode_d  = mode_q;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (gate_i[v]) begin
                        state_d = RUN;
                        half_d  = half_new;
                        mode_d  = mode_i[2*v +: 2];
                    end
                end
                RUN: begin
                    if (!gate_i[v]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (sync_i[v] || term) begin
                        cnt_d  = '0;
                        half_d = half_new;
                        mode_d = mode_i[2*v +: 2];
                    end else begin
                        cnt_d = cnt_q + CNT_BW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                half_q  <= '0;
                mode_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                half_q  <= half_d;
                mode_q  <= mode_d;
            end
        end

        assign wave_o[v] = (state_q == RUN) & ((cnt_q < thr) ^ (mode_q == 2'd3));
        assign wrap_o[v] = (state_q == RUN) & term;
    end

    logic [MIX_BW-1:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            pop = pop + MIX_BW'(wave_o[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) mix_o <= '0;
        else       mix_o <= pop;
    end

endmodule

// File: tb/tb_poly_osc.sv
// tb/tb_poly_osc.sv - table-driven and sequence checks for poly_osc (1 MHz, 14-bit counters)
module tb_poly_osc;

    localparam int NV     = 4;
    localparam int MIX_BW = $clog2(NV + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [8*NV-1:0]   note = '0;
    logic [NV-1:0]     gate = '0;
    logic [NV-1:0]     sync = '0;
    logic [2*NV-1:0]   mode = '0;
    logic [NV-1:0]     wave;
    logic [NV-1:0]     wrap;
    logic [MIX_BW-1:0] mix;

    int nchk = 0;
    int nerr = 0;

    poly_osc #(
        .F_CLK_HZ  (1_000_000),
        .NUM_VOICES(NV),
        .CNT_BW    (14)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .note_i(note),
        .gate_i(gate),
        .sync_i(sync),
        .mode_i(mode),
        .wave_o(wave),
        .wrap_o(wrap),
        .mix_o (mix)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int popc(input logic [NV-1:0] w);
        int c = 0;
        for (int i = 0; i < NV; i++) c += int'(w[i]);
        return c;
    endfunction

    typedef struct {
        int v;
        int nt;
        int md;
        int lvl1;
        int len1;
        int len2;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // Half periods at 1 MHz: TOP[0]=59, TOP[7]=39, TOP[9]=35; 14-bit counter saturates half to 8191.
        vecs[0]  = '{0, 69,  0, 1, 1120, 1120};
        vecs[1]  = '{1, 69,  1, 1, 560,  1680};
        vecs[2]  = '{2, 69,  2, 1, 280,  1960};
        vecs[3]  = '{3, 69,  3, 0, 1120, 1120};
        vecs[4]  = '{0, 200, 0, 1, 39,   39};
        vecs[5]  = '{1, 127, 1, 1, 19,   59};
        vecs[6]  = '{2, 200, 2, 1, 9,    69};
        vecs[7]  = '{3, 0,   0, 1, 8191, 8191};
        vecs[8]  = '{0, 57,  3, 0, 2240, 2240};
        vecs[9]  = '{1, 45,  0, 1, 4480, 4480};
        vecs[10] = '{2, 108, 3, 0, 118,  118};
        vecs[11] = '{3, 60,  1, 1, 944,  2832};

        step();
        chk("reset_wave", int'(wave), 0);
        chk("reset_wrap", int'(wrap), 0);
        chk("reset_mix",  int'(mix),  0);
        rst = 1'b0;
        step();

        for (int k = 0; k < 12; k++) begin
            int n1, n2, widx, phase, lim;
            gate = '0;
            sync = '0;
            step();
            step();
            note[8*vecs[k].v +: 8] = 8'(vecs[k].nt);
            mode[2*vecs[k].v +: 2] = 2'(vecs[k].md);
            gate[vecs[k].v] = 1'b1;
            step();
            n1 = 0; n2 = 0; widx = -1; phase = 0;
            lim = vecs[k].len1 + vecs[k].len2 + 5;
            for (int i = 0; i < lim; i++) begin
                if (wrap[vecs[k].v] && widx < 0) widx = i;
                if (phase == 0) begin
                    if (int'(wave[vecs[k].v]) == vecs[k].lvl1) n1++;
                    else begin phase = 1; n2++; end
                end else begin
                    if (int'(wave[vecs[k].v]) != vecs[k].lvl1) n2++;
                    else break;
                end
                step();
            end
            chk($sformatf("vec%0d_first", k),  n1,   vecs[k].len1);
            chk($sformatf("vec%0d_second", k), n2,   vecs[k].len2);
            chk($sformatf("vec%0d_wrap", k),   widx, vecs[k].len1 + vecs[k].len2 - 1);
        end

        // Note change mid-period: current period finishes, then the new one applies.
        begin
            int wraps[$];
            int hi;
            gate = '0; step(); step();
            note[7:0] = 8'd69; mode[1:0] = 2'd0; gate[0] = 1'b1;
            step();
            hi = 0;
            for (int i = 0; i < 3500; i++) begin
                if (wrap[0]) wraps.push_back(i);
                if (i >= 2240 && i < 3360 && wave[0]) hi++;
                if (i == 500) note[7:0] = 8'd81;
                step();
            end
            chk("chg_nwraps", wraps.size(), 2);
            chk("chg_wrap0", (wraps.size() > 0) ? wraps[0] : -1, 2239);
            chk("chg_wrap1", (wraps.size() > 1) ? wraps[1] : -1, 3359);
            chk("chg_high", hi, 560);
        end

        // Sync mid-period restarts the count with no wrap for the truncated period.
        begin
            int fwrap, ffall;
            gate = '0; step(); step();
            note[15:8] = 8'd69; mode[3:2] = 2'd0; gate[1] = 1'b1;
            step();
            fwrap = -1; ffall = -1;
            for (int i = 0; i < 3000; i++) begin
                if (wrap[1] && fwrap < 0) fwrap = i;
                if (!wave[1] && ffall < 0) ffall = i;
                sync[1] = (i == 500);
                step();
            end
            sync = '0;
            chk("sync_first_wrap", fwrap, 2740);
            chk("sync_first_low", ffall, 1621);
        end

        // Sync in IDLE is ignored; gate fall clears the wave on the next cycle.
        begin
            int w100, w101, acc;
            gate = '0; step(); step();
            sync[3] = 1'b1;
            acc = 0;
            for (int i = 0; i < 5; i++) begin
                acc += int'(wave[3]) + int'(wrap[3]);
                step();
            end
            sync = '0;
            chk("idle_sync", acc, 0);
            note[23:16] = 8'd69; mode[5:4] = 2'd0; gate[2] = 1'b1;
            step();
            w100 = -1; w101 = -1;
            for (int i = 0; i < 102; i++) begin
                if (i == 100) begin w100 = int'(wave[2]); gate[2] = 1'b0; end
                if (i == 101) w101 = int'(wave[2]);
                step();
            end
            chk("gate_fall_before", w100, 1);
            chk("gate_fall_after",  w101, 0);
        end

        // Four voices, staggered gates: mix tracks the previous cycle's wave popcount.
        begin
            logic [NV-1:0] prev;
            int bad, maxm;
            gate = '0; step(); step();
            note = {8'd72, 8'd67, 8'd64, 8'd60};
            mode = '0;
            prev = wave;
            bad = 0; maxm = 0;
            for (int i = 0; i < 4000; i++) begin
                if (i > 0 && int'(mix) != popc(prev)) bad++;
                if (int'(mix) > maxm) maxm = int'(mix);
                prev = wave;
                if (i % 10 == 0 && i < 40) gate[i / 10] = 1'b1;
                step();
            end
            chk("mix_mismatches", bad, 0);
            chk("mix_max", maxm, 4);
        end

        // Asynchronous reset between edges, then restart with gate held.
        begin
            int hi;
            gate = '0; step(); step();
            note[7:0] = 8'd69; mode[1:0] = 2'd0; gate[0] = 1'b1;
            step();
            for (int i = 0; i < 200; i++) step();
            #2;
            rst = 1'b1;
            #1;
            chk("arst_wave", int'(wave), 0);
            chk("arst_wrap", int'(wrap), 0);
            chk("arst_mix",  int'(mix),  0);
            @(posedge clk);
            #2;
            rst = 1'b0;
            step();
            chk("arst_restart_wave", int'(wave[0]), 1);
            hi = 0;
            for (int i = 0; i < 1200; i++) begin
                if (!wave[0]) break;
                hi++;
                step();
            end
            chk("arst_restart_high", hi, 1120);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
